// File: rtl/dds_phase_engine_if.sv
// Control/status bundle of the DDS phase engine: tuning, sweep and phase-offset
// inputs plus the truncated phase and sequencing flags going to the LUT/sequencer.
interface dds_phase_engine_if #(
    parameter int ACC_WIDTH   = 24,
    parameter int PHASE_WIDTH = 10
);
    logic                   enable;
    logic [ACC_WIDTH-1:0]   ftw_in;
    logic                   ftw_load;
    logic [PHASE_WIDTH-1:0] pow_in;
    logic                   sync_clr;
    logic                   sweep_start;
    logic [ACC_WIDTH-1:0]   sweep_step;
    logic [ACC_WIDTH-1:0]   sweep_stop;
    logic [PHASE_WIDTH-1:0] phase_out;
    logic                   phase_valid;
    logic                   wrap;
    logic                   sweep_done;
    logic                   busy;

    modport master (
        output enable, ftw_in, ftw_load, pow_in, sync_clr,
               sweep_start, sweep_step, sweep_stop,
        input  phase_out, phase_valid, wrap, sweep_done, busy
    );

    modport slave (
        input  enable, ftw_in, ftw_load, pow_in, sync_clr,
               sweep_start, sweep_step, sweep_stop,
        output phase_out, phase_valid, wrap, sweep_done, busy
    );
endinterface

// File: rtl/dds_phase_engine.sv
// Phase accumulator with loadable FTW, phase offset and linear chirp sweep.
// Optional phase dithering before truncation: define DDS_PHASE_DITHER_EN.
module dds_phase_engine #(
    parameter int                   ACC_WIDTH   = 24,
    parameter int                   PHASE_WIDTH = 10,
    parameter logic [ACC_WIDTH-1:0] FTW_RESET   = 24'h040000
) (
    input  logic              clock,
    input  logic              reset,
    dds_phase_engine_if.slave bus
);
    localparam int FRAC_WIDTH = ACC_WIDTH - PHASE_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SWEEP} state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [ACC_WIDTH-1:0]   ftw_q, ftw_d;
    logic [ACC_WIDTH-1:0]   step_q, step_d;
    logic [ACC_WIDTH-1:0]   stop_q, stop_d;
    logic                   carry_q, carry_d;
    logic                   done_pend_q, done_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic                   valid_q, wrap_q, sweep_done_q, busy_q;
    logic [ACC_WIDTH:0]     sum_acc, sum_ftw;
    logic [ACC_WIDTH-1:0]   acc_view;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ftw_d   = ftw_q;
        step_d  = step_q;
        stop_d  = stop_q;
        carry_d = 1'b0;
        done_d  = 1'b0;
        sum_acc = {1'b0, acc_q} + {1'b0, ftw_q};
        sum_ftw = {1'b0, ftw_q} + {1'b0, step_q};
        case (state_q)
            ST_IDLE: begin
                if (bus.ftw_load) ftw_d = bus.ftw_in;
                if (bus.enable)   state_d = ST_RUN;
            end
            ST_RUN: begin
                acc_d   = sum_acc[ACC_WIDTH-1:0];
                carry_d = sum_acc[ACC_WIDTH];
                if (!bus.enable) state_d = ST_IDLE;
                // A load in the same cycle as a sweep request takes precedence.
                if (bus.ftw_load) begin
                    ftw_d = bus.ftw_in;
                end else if (bus.sweep_start && bus.enable) begin
                    state_d = ST_SWEEP;
                    step_d  = bus.sweep_step;
                    stop_d  = bus.sweep_stop;
                end
            end
            ST_SWEEP: begin
                acc_d   = sum_acc[ACC_WIDTH-1:0];
                carry_d = sum_acc[ACC_WIDTH];
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else if (sum_ftw >= {1'b0, stop_q}) begin
                    ftw_d   = stop_q;
                    done_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    ftw_d = sum_ftw[ACC_WIDTH-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.sync_clr) begin
            acc_d   = '0;
            carry_d = 1'b0;
        end
    end

`ifdef DDS_PHASE_DITHER_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 16'hACE1;
        end else if (state_q != ST_IDLE) begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    // Dither only shapes the truncation of the output; acc stays exact.
    assign acc_view = acc_q + {{PHASE_WIDTH{1'b0}}, lfsr_q[FRAC_WIDTH-1:0]};
`else
    assign acc_view = acc_q;
`endif

    assign phase_d = acc_view[ACC_WIDTH-1 -: PHASE_WIDTH] + bus.pow_in;

    // carry/done are staged once more so they line up with the phase they caused.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            ftw_q        <= FTW_RESET;
            step_q       <= '0;
            stop_q       <= '0;
            carry_q      <= 1'b0;
            done_pend_q  <= 1'b0;
            phase_q      <= '0;
            valid_q      <= 1'b0;
            wrap_q       <= 1'b0;
            sweep_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            ftw_q        <= ftw_d;
            step_q       <= step_d;
            stop_q       <= stop_d;
            carry_q      <= carry_d;
            done_pend_q  <= done_d;
            phase_q      <= phase_d;
            valid_q      <= (state_q != ST_IDLE);
            wrap_q       <= carry_q;
            sweep_done_q <= done_pend_q;
            busy_q       <= (state_d == ST_SWEEP);
        end
    end

    assign bus.phase_out   = phase_q;
    assign bus.phase_valid = valid_q;
    assign bus.wrap        = wrap_q;
    assign bus.sweep_done  = sweep_done_q;
    assign bus.busy        = busy_q;
endmodule

// File: doc/dds_phase_engine.md
# dds_phase_engine

Parametrised phase-generation core for the direct digital synthesizer, replacing the fixed-increment phase accumulator. It holds a wide phase accumulator with a runtime-loadable frequency tuning word (FTW), a phase offset, and a linear frequency-sweep (chirp) mode. Its truncated phase output feeds the sine lookup table; `wrap` and `sweep_done` feed the control/sequencing logic.

## Interface
- `ACC_WIDTH`, 24: accumulator and FTW width; the accumulator wraps modulo 2^ACC_WIDTH.
- `PHASE_WIDTH`, 10: phase output width (the LUT address). Constraint: PHASE_WIDTH < ACC_WIDTH and ACC_WIDTH − PHASE_WIDTH ≤ 16.
- `FTW_RESET`, 24'h040000: FTW value loaded at reset. At 1 MHz this gives the legacy 16-per-cycle phase step.
- `clock` input 1: single clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `enable` input 1: 1 runs the accumulator; 0 holds it (IDLE).
- `ftw_in` input ACC_WIDTH: new FTW value.
- `ftw_load` input 1: 1-cycle strobe that captures `ftw_in`.
- `pow_in` input PHASE_WIDTH: phase offset word, sampled every cycle.
- `sync_clr` input 1: synchronous clear of the accumulator.
- `sweep_start` input 1: 1-cycle strobe that starts a sweep from the active FTW.
- `sweep_step` input ACC_WIDTH: FTW increment per sweep cycle, sampled at `sweep_start`.
- `sweep_stop` input ACC_WIDTH: final FTW of the sweep, sampled at `sweep_start`.
- `phase_out` output PHASE_WIDTH: registered phase.
- `phase_valid` output 1: `phase_out` reflects a running accumulator.
- `wrap` output 1: 1-cycle pulse on accumulator overflow.
- `sweep_done` output 1: 1-cycle pulse when a sweep reaches `sweep_stop`.
- `busy` output 1: high while in SWEEP.

## Operation
- Registers: `acc` (ACC_WIDTH), `ftw_act` (ACC_WIDTH), latched step and stop values, and a state register.
- **IDLE**
  - `acc` holds its value.
  - `enable`=1 → RUN.
- **RUN**
  - Each cycle, `acc` ← `acc` + `ftw_act` (mod 2^ACC_WIDTH); the carry-out sets `wrap`.
  - `sweep_start`=1 → SWEEP, latching `sweep_step` and `sweep_stop`.
  - `enable`=0 → IDLE.
- **SWEEP**
  - Each cycle, `acc` ← `acc` + `ftw_act`.
  - If `ftw_act` + step ≥ stop (unsigned, computed at ACC_WIDTH+1 bits), then `ftw_act` ← stop, pulse `sweep_done`, and go to RUN.
  - Otherwise `ftw_act` ← `ftw_act` + step.
  - `enable`=0 → IDLE with the sweep aborted: `ftw_act` keeps its current value and there is no `sweep_done`.
- `sweep_start` in IDLE or SWEEP is ignored. A step of 0 with stop > `ftw_act` never terminates; that case is allowed.
- `ftw_load` is accepted in IDLE and RUN and sets `ftw_act` ← `ftw_in`. It is ignored in SWEEP.
- In RUN, `ftw_load` and `sweep_start` asserted together: the load wins and the sweep is ignored.
- `sync_clr` sets `acc` ← 0 in any state and overrides that cycle's addition. It does not change `ftw_act` or the state, and produces no `wrap`.
- `phase_out` ← `acc`[ACC_WIDTH−1 −: PHASE_WIDTH] + `pow_in`, taken mod 2^PHASE_WIDTH.
- Reset values:
  - `acc`=0, `ftw_act`=FTW_RESET, state=IDLE.
  - `phase_out`=0.
  - `phase_valid`=0, `wrap`=0, `sweep_done`=0, `busy`=0.
- Reset asserted mid-sweep aborts the sweep immediately and applies the reset values above.

## Timing
- An `acc` update at edge k appears on `phase_out` at edge k+1. `pow_in` is sampled at edge k+1.
- `wrap` and `sweep_done` are registered so they align with the `phase_out` value that reflects the triggering update.
- `phase_valid` is high one cycle after the IDLE→RUN transition. It drops at the first edge after IDLE is entered.
- A loaded FTW is first used in the addition of the cycle after the `ftw_load` edge.
- `busy` rises at the edge that enters SWEEP and falls at the edge that leaves it.

## Configuration
- `DDS_PHASE_DITHER_EN` defined:
  - A 16-bit Galois LFSR with polynomial x^16+x^14+x^13+x^11+1 is added.
  - Its seed is 16'hACE1 at reset, and it advances every cycle when not in IDLE.
  - Its low ACC_WIDTH−PHASE_WIDTH bits are added to the truncated bits of `acc` before truncation, for the `phase_out` computation only.
  - `acc` itself is never dithered.
- `DDS_PHASE_DITHER_EN` undefined: plain truncation and no LFSR logic.
- All tests below run with the macro undefined.

## Test plan
- **Free run:** reset, FTW 24'h040000, `enable`=1 → `phase_out` = 16, 32, …, 1008, 0. `wrap` pulses exactly with the 0, then every 64 cycles.
- **Offset:** `pow_in`=512 with the free-run stimulus → `phase_out` = 528, 544, …, and shows 512 on the wrap cycle.
- **Sweep:** `ftw_load` 24'h010000, then `sweep_start` with step 24'h010000 and stop 24'h040000.
  - Additions are 0x10000, 0x20000, 0x30000.
  - `sweep_done` pulses after the third, `busy` is high for 3 cycles, and `ftw_act` ends at 0x40000.
  - A `ftw_load` during the sweep is ignored.
- **Reset mid-sweep:** `reset` low during the second sweep cycle → all outputs are 0 immediately, state is IDLE, `ftw_act`=FTW_RESET, and there is no `sweep_done`.
- **Simultaneous events:** `sync_clr` together with `ftw_load` in RUN → `acc`=0 and the new FTW is used from the next cycle. `enable`=0 → `phase_out` frozen and `phase_valid`=0.
- **Priority:** `ftw_load` together with `sweep_start` in RUN → FTW updated, `busy` stays 0.
